// File: rtl/branch_pc_if.sv
// Fetch-redirect bus between the ID stage / instruction memory and branch_pc.
// master drives branch/jump requests and memory readiness; slave returns the fetch PC.
interface branch_pc_if;
    logic        stall;
    logic [2:0]  br_type;
    logic        isbeq;
    logic        isbne;
    logic        isblez;
    logic        isbgtz;
    logic        isbltz;
    logic        isbgez;
    logic [15:0] imm16;
    logic        jmp;
    logic [25:0] jidx;
    logic        jr;
    logic [31:0] jr_tgt;
    logic        if_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic        taken;
    logic [31:0] taken_cnt;

    modport master (
        output stall, br_type, isbeq, isbne, isblez, isbgtz, isbltz, isbgez,
               imm16, jmp, jidx, jr, jr_tgt, if_ready,
        input  pc, pc_valid, taken, taken_cnt
    );

    modport slave (
        input  stall, br_type, isbeq, isbne, isblez, isbgtz, isbltz, isbgez,
               imm16, jmp, jidx, jr, jr_tgt, if_ready,
        output pc, pc_valid, taken, taken_cnt
    );
endinterface

// File: rtl/branch_pc.sv
// IF-stage program counter with delayed-branch redirect (jr > jmp > branch) and fetch back-pressure.
// Optional feature macro: BRANCH_PC_TAKEN_CNT_EN builds the saturating taken_cnt counter.
module branch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    branch_pc_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] pend_tgt_r;
    logic [31:0] pend_nxt_s;
    logic        taken_r;
    logic        taken_nxt_s;
    logic        pc_valid_r;

    logic        cond_s;
    logic [31:0] br_off_s;
    logic [31:0] br_tgt_s;
    logic [31:0] j_tgt_s;
    logic [31:0] jr_tgt_s;
    logic        req_s;
    logic [31:0] tgt_s;
    logic [31:0] fetch_pc_s;

    // Branch condition select from the comparator flags; reserved type never branches.
    always_comb begin
        cond_s = 1'b0;
        case (bus.br_type)
            3'd1:    cond_s = bus.isbeq;
            3'd2:    cond_s = bus.isbne;
            3'd3:    cond_s = bus.isblez;
            3'd4:    cond_s = bus.isbgtz;
            3'd5:    cond_s = bus.isbltz;
            3'd6:    cond_s = bus.isbgez;
            default: cond_s = 1'b0;
        endcase
    end

    // pc already points at the delay slot, so offsets are relative to it.
    assign br_off_s = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign br_tgt_s = pc_r + br_off_s;
    assign j_tgt_s  = {pc_r[31:28], bus.jidx, 2'b00};
    assign jr_tgt_s = bus.jr_tgt & ~32'h0000_0003;

    // Requests are only honoured once the fetch port is live and decode is not stalled.
    assign req_s = pc_valid_r & ~bus.stall & (bus.jr | bus.jmp | cond_s);

    // Redirect target with jr > jmp > conditional branch priority.
    always_comb begin
        if (bus.jr) begin
            tgt_s = jr_tgt_s;
        end else if (bus.jmp) begin
            tgt_s = j_tgt_s;
        end else begin
            tgt_s = br_tgt_s;
        end
    end

    // Address issued when memory accepts this cycle's fetch.
    always_comb begin
        if (bus.stall) begin
            fetch_pc_s = pc_r;
        end else if (req_s) begin
            fetch_pc_s = tgt_s;
        end else begin
            fetch_pc_s = pc_r + 32'd4;
        end
    end

    // Next-state and datapath updates; the first cycle after reset release only arms pc_valid.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        pend_nxt_s  = pend_tgt_r;
        taken_nxt_s = 1'b0;
        if (pc_valid_r) begin
            case (state_r)
                ST_RUN: begin
                    if (bus.if_ready) begin
                        pc_nxt_s    = fetch_pc_s;
                        taken_nxt_s = req_s;
                    end else if (req_s) begin
                        pend_nxt_s  = tgt_s;
                        state_nxt_s = ST_PEND;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.if_ready) begin
                        pc_nxt_s    = fetch_pc_s;
                        taken_nxt_s = req_s;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_PEND: begin
                    // Delay slot still unfetched: new requests are ignored until it goes out.
                    if (bus.if_ready) begin
                        pc_nxt_s    = pend_tgt_r;
                        taken_nxt_s = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PEND;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = RESET_PC;
                end
            endcase
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // State, PC, pending target and status registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            pend_tgt_r <= 32'h0000_0000;
            taken_r    <= 1'b0;
            pc_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            pend_tgt_r <= pend_nxt_s;
            taken_r    <= taken_nxt_s;
            pc_valid_r <= 1'b1;
        end
    end

`ifdef BRANCH_PC_TAKEN_CNT_EN
    logic [31:0] taken_cnt_r;

    // Saturating count of applied redirects, in step with taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            taken_cnt_r <= 32'h0000_0000;
        end else if (taken_nxt_s && (taken_cnt_r != 32'hFFFF_FFFF)) begin
            taken_cnt_r <= taken_cnt_r + 32'd1;
        end else begin
            taken_cnt_r <= taken_cnt_r;
        end
    end

    assign bus.taken_cnt = taken_cnt_r;
`else
    assign bus.taken_cnt = 32'h0000_0000;
`endif

    assign bus.pc       = pc_r;
    assign bus.pc_valid = pc_valid_r;
    assign bus.taken    = taken_r;

endmodule

// File: tb/tb_branch_pc.sv
// Directed plus randomized bench for branch_pc against a behavioural fetch/redirect model.
module tb_branch_pc;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_pc_if bus();

    branch_pc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic        m_wait;
    logic        m_taken;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic        flags [8];
        logic        req;
        logic [31:0] tgt;
        logic signed [31:0] off;
        flags[0] = 1'b0;        flags[1] = bus.isbeq;  flags[2] = bus.isbne;
        flags[3] = bus.isblez;  flags[4] = bus.isbgtz; flags[5] = bus.isbltz;
        flags[6] = bus.isbgez;  flags[7] = 1'b0;
        off = {{16{bus.imm16[15]}}, bus.imm16};
        if (bus.jr)        tgt = {bus.jr_tgt[31:2], 2'b00};
        else if (bus.jmp)  tgt = {m_pc[31:28], bus.jidx, 2'b00};
        else               tgt = m_pc + off * 4;
        req = !bus.stall && (bus.jr || bus.jmp || flags[bus.br_type]);
        if (!reset) begin
            m_pc = 32'h0000_3000; m_valid = 1'b0; m_pend = 1'b0; m_pend_tgt = 32'h0;
            m_wait = 1'b0; m_taken = 1'b0; m_cnt = 32'h0;
        end else if (!m_valid) begin
            m_valid = 1'b1; m_taken = 1'b0;
        end else begin
            m_taken = 1'b0;
            if (m_pend) begin
                if (bus.if_ready) begin
                    m_pc = m_pend_tgt; m_pend = 1'b0; m_taken = 1'b1;
                end
            end else if (bus.if_ready) begin
                m_wait = 1'b0;
                if (req) begin
                    m_pc = tgt; m_taken = 1'b1;
                end else if (!bus.stall) begin
                    m_pc = m_pc + 32'd4;
                end
            end else if (!m_wait) begin
                if (req) begin
                    m_pend = 1'b1; m_pend_tgt = tgt;
                end else begin
                    m_wait = 1'b1;
                end
            end
`ifdef BRANCH_PC_TAKEN_CNT_EN
            if (m_taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("pc",        bus.pc,              m_pc);
        chk("pc_valid",  {31'd0, bus.pc_valid}, {31'd0, m_valid});
        chk("taken",     {31'd0, bus.taken},  {31'd0, m_taken});
        chk("taken_cnt", bus.taken_cnt,       m_cnt);
        chk("pc_align",  {30'd0, bus.pc[1:0]}, 32'd0);
    endtask

    task automatic idle();
        bus.stall = 1'b0; bus.br_type = 3'd0;
        bus.isbeq = 1'b0; bus.isbne = 1'b0; bus.isblez = 1'b0;
        bus.isbgtz = 1'b0; bus.isbltz = 1'b0; bus.isbgez = 1'b0;
        bus.imm16 = 16'h0000; bus.jmp = 1'b0; bus.jidx = 26'h0;
        bus.jr = 1'b0; bus.jr_tgt = 32'h0;
    endtask

    int taken_seen;

    initial begin
        idle();
        bus.if_ready = 1'b1;
        reset = 1'b0;
        m_pc = 32'h0; m_valid = 1'b0; m_pend = 1'b0; m_pend_tgt = 32'h0;
        m_wait = 1'b0; m_taken = 1'b0; m_cnt = 32'h0;

        // Reset state
        tick();
        chk("rst_pc", bus.pc, 32'h0000_3000);
        chk("rst_valid", {31'd0, bus.pc_valid}, 32'd0);
        reset = 1'b1;
        tick();
        chk("warm_pc", bus.pc, 32'h0000_3000);
        chk("warm_valid", {31'd0, bus.pc_valid}, 32'd1);

        // Free run
        tick(); chk("run1", bus.pc, 32'h0000_3004);
        tick(); chk("run2", bus.pc, 32'h0000_3008);
        tick(); tick(); chk("run4", bus.pc, 32'h0000_3010);

        // beq taken backward
        bus.br_type = 3'd1; bus.isbeq = 1'b1; bus.imm16 = 16'hFFFC;
        tick(); chk("beq_t_pc", bus.pc, 32'h0000_3000);
        chk("beq_t_taken", {31'd0, bus.taken}, 32'd1);
        idle();
        repeat (4) tick();
        chk("back_3010", bus.pc, 32'h0000_3010);
        bus.br_type = 3'd1; bus.isbeq = 1'b0; bus.imm16 = 16'hFFFC;
        tick(); chk("beq_nt_pc", bus.pc, 32'h0000_3014);
        chk("beq_nt_taken", {31'd0, bus.taken}, 32'd0);
        idle();

        // jr beats jmp, low bits cleared
        bus.jr = 1'b1; bus.jr_tgt = 32'h0000_3103; bus.jmp = 1'b1; bus.jidx = 26'h0000_040;
        tick(); chk("jr_prio", bus.pc, 32'h0000_3100);
        idle();
        tick(); chk("after_jr", bus.pc, 32'h0000_3104);

        // Branch while memory is busy for three cycles
        bus.br_type = 3'd2; bus.isbne = 1'b1; bus.imm16 = 16'h0010;
        bus.if_ready = 1'b0;
        taken_seen = 0;
        tick(); chk("pend_hold1", bus.pc, 32'h0000_3104);
        idle();
        tick(); chk("pend_hold2", bus.pc, 32'h0000_3104);
        tick(); chk("pend_hold3", bus.pc, 32'h0000_3104);
        taken_seen += int'(bus.taken);
        bus.if_ready = 1'b1;
        tick(); chk("pend_apply", bus.pc, 32'h0000_3144);
        taken_seen += int'(bus.taken);
        tick(); taken_seen += int'(bus.taken);
        chk("pend_taken_once", taken_seen, 32'd1);

        // Stall holds, then request is sampled
        bus.stall = 1'b1; bus.br_type = 3'd4; bus.isbgtz = 1'b1; bus.imm16 = 16'h0002;
        tick(); chk("stall_hold", bus.pc, 32'h0000_3148);
        bus.stall = 1'b0;
        tick(); chk("stall_release", bus.pc, 32'h0000_3150);
        idle();

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bus.stall    = ($urandom_range(0, 5) == 0);
            bus.br_type  = 3'($urandom_range(0, 7));
            bus.isbeq    = 1'($urandom); bus.isbne  = 1'($urandom);
            bus.isblez   = 1'($urandom); bus.isbgtz = 1'($urandom);
            bus.isbltz   = 1'($urandom); bus.isbgez = 1'($urandom);
            bus.imm16    = 16'($urandom);
            bus.jmp      = ($urandom_range(0, 7) == 0);
            bus.jidx     = 26'($urandom);
            bus.jr       = ($urandom_range(0, 9) == 0);
            bus.jr_tgt   = $urandom;
            bus.if_ready = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 63) != 0);
            tick();
        end
        reset = 1'b1; bus.if_ready = 1'b1; idle();

        // Five taken branches after a fresh reset
        reset = 1'b0; tick(); reset = 1'b1; tick();
        for (int k = 0; k < 5; k++) begin
            bus.br_type = 3'd6; bus.isbgez = 1'b1; bus.imm16 = 16'h0004;
            tick();
            idle();
            tick();
        end
`ifdef BRANCH_PC_TAKEN_CNT_EN
        chk("cnt_five", bus.taken_cnt, 32'd5);
`else
        chk("cnt_off", bus.taken_cnt, 32'd0);
`endif

        // Reset while a redirect is pending
        bus.if_ready = 1'b0; bus.jmp = 1'b1; bus.jidx = 26'h0000_400;
        tick();
        idle();
        reset = 1'b0;
        tick(); chk("pend_rst_pc", bus.pc, 32'h0000_3000);
        reset = 1'b1; bus.if_ready = 1'b1;
        tick(); chk("pend_rst_warm", bus.pc, 32'h0000_3000);
        tick(); chk("pend_discarded", bus.pc, 32'h0000_3004);
        chk("pend_rst_taken", {31'd0, bus.taken}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
